int_issue: RTL and testbench
============================

Name: int_issue

Overview:
- Issue stage directly upstream of int_alu.
- Accepts one decoded RV64I integer instruction per cycle, together with its register-file read data.
- Blocks read-after-write hazards with a 32-entry scoreboard and captures operands into a DEPTH-entry in-order buffer.
- Presents instruction, inst_type, data_a and data_b to int_alu with a valid/ready handshake; the writeback port clears scoreboard bits.

Parameters:
- XLEN, 64, operand and result width.
- DEPTH, 2, issue buffer entries (power of two, minimum 2).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_instruction  in  32  raw instruction word.
- rs1_data  in  XLEN  register-file read of in_instruction[19:15].
- rs2_data  in  XLEN  register-file read of in_instruction[24:20].
- out_valid  out  1  head entry valid towards int_alu.
- out_ready  in  1  int_alu/result path accepts.
- instruction  out  32  head entry instruction.
- inst_type  out  3  head entry instruction[14:12].
- data_a  out  XLEN  head entry captured rs1 operand.
- data_b  out  XLEN  head entry captured rs2 operand.
- out_rd  out  5  head entry destination register.
- wb_valid  in  1  writeback of a previously issued result.
- wb_rd  in  5  writeback destination.
- wb_data  in  XLEN  writeback value.
- illegal_inst  out  1  one-cycle pulse: unsupported opcode dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - Buffer empties; count=0.
  - Scoreboard cleared to all zeros.
  - Outputs: out_valid=0, illegal_inst=0, instruction/data_a/data_b/out_rd=0.
  - Reset mid-operation discards all buffered entries and all pending bits.
- Opcode = in_instruction[6:0]:
  - OP (0110011): reads rs1 and rs2.
  - OP-IMM (0010011): reads rs1 only; captures rs2_data unmodified.
  - Any other opcode: accepted when in_ready=1, not buffered, scoreboard untouched, illegal_inst=1 the next cycle.
- Hazard:
  - A source register is busy when its pending bit=1 and it is nonzero; x0 is never busy.
  - With FORWARD_EN, a busy source is released when wb_valid=1 and wb_rd equals that source in the same cycle.
- in_ready = (count<DEPTH) and no busy source. It is evaluated without regard to out_ready in the same cycle; accepting while full and popping in the same cycle is not supported.
- Accept (in_valid and in_ready, legal opcode):
  - Writes the tail entry with instruction, rd=[11:7], operands (forwarded if applicable).
  - Sets pending[rd] when rd≠0.
  - The entry is visible at out_* the next cycle; issue latency is 1 cycle.
- Issue: out_valid=(count>0). The head pops on out_valid and out_ready. out_* must hold stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop: count unchanged; pointers both advance and wrap modulo DEPTH.
- Writeback: wb_valid clears pending[wb_rd]; wb_rd=0 is ignored.
- Same-cycle set and clear of the same register: set wins, because the new producer owns the register.
- Arithmetic: none. Operands pass unmodified at full XLEN.

Optional Feature:
- Macro: INT_ISSUE_FORWARD_EN.
- Defined:
  - A writeback matching a busy source in the same cycle releases the stall.
  - wb_data replaces rs1_data/rs2_data in the captured entry.
- Undefined:
  - A pending source stalls until its bit is already clear at the start of the cycle, costing 1 extra cycle per dependency.
  - No wb_data mux is built.

Decomposition:
- Shared package int_pkg holds:
  - XLEN.
  - Opcode constants OPC_OP=7'b0110011 and OPC_OP_IMM=7'b0010011.
  - Register index width (5).
- Sub-module int_scoreboard: a 32-bit pending vector with set/clear ports, set priority, and two combinational busy queries.

Test Plan:
- Reset, then push ADD x3,x1,x2 with rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, data_a=5, data_b=7, inst_type=000, out_rd=3, pending[3]=1.
- Back-to-back ADD x3 then SUB x4,x3,x1 → second held with in_ready=0. wb_valid, wb_rd=3, wb_data=12:
  - FORWARD_EN: accepted that cycle with data_a=12.
  - Without: accepted one cycle later.
- out_ready=0, push 2 legal instructions → in_ready=0 at count=2 and out_* stable. Raise out_ready → both drain in order, count returns to 0.
- ADDI x5,x0,1 then ADD x6,x0,x0 → never stall, because x0 is not tracked; ADDI with rs2 field=5 while pending[5]=1 does not stall.
- Opcode 0000011 pushed → no out_valid, illegal_inst one-cycle pulse, scoreboard unchanged.
- Buffer full with pending[3]=1, assert reset=0 asynchronously → out_valid and in-flight state drop immediately; after release, pending=0 and in_ready=1.

Source files
------------

// File: rtl/int_pkg.sv
// Shared definitions for the integer issue stage: widths, opcodes and buffer entry layout.
package int_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // Non-operand part of an issue buffer entry.
  typedef struct packed {
    logic [31:0]      instr;
    logic [REG_W-1:0] rd;
  } iq_meta_t;

  function automatic logic is_legal_opc(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM);
  endfunction

endpackage

// File: rtl/int_scoreboard.sv
// 32-entry pending-write scoreboard; a same-cycle set beats a clear of the same register.
module int_scoreboard
  import int_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_rd,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_rd,
  input  logic [REG_W-1:0] query_a,
  input  logic [REG_W-1:0] query_b,
  output logic             busy_a_c,
  output logic             busy_b_c
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en && (clr_rd != '0)) pending_d[clr_rd] = 1'b0;
    if (set_en && (set_rd != '0)) pending_d[set_rd] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // x0 is never tracked, so it can never report busy.
  assign busy_a_c = pending_q[query_a] && (query_a != '0);
  assign busy_b_c = pending_q[query_b] && (query_b != '0);

endmodule

// File: rtl/int_issue.sv
// Integer issue stage: RAW hazard blocking plus an in-order operand buffer feeding int_alu.
// Optional same-cycle writeback forwarding under macro INT_ISSUE_FORWARD_EN.
module int_issue #(
  parameter int unsigned XLEN  = int_pkg::XLEN,
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instruction,
  input  logic [XLEN-1:0]           rs1_data,
  input  logic [XLEN-1:0]           rs2_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               instruction,
  output logic [2:0]                inst_type,
  output logic [XLEN-1:0]           data_a,
  output logic [XLEN-1:0]           data_b,
  output logic [int_pkg::REG_W-1:0] out_rd,
  input  logic                      wb_valid,
  input  logic [int_pkg::REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  output logic                      illegal_inst
);

  import int_pkg::*;

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [6:0]       opcode;
  logic [REG_W-1:0] src_a;
  logic [REG_W-1:0] src_b;
  logic [REG_W-1:0] dst;
  logic             is_op;
  logic             legal;
  logic             busy_a;
  logic             busy_b;
  logic             stall_a;
  logic             stall_b;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic             push;
  logic             drop;
  logic             pop;

  iq_meta_t         meta_q [DEPTH];
  iq_meta_t         meta_d [DEPTH];
  logic [XLEN-1:0]  opa_q  [DEPTH];
  logic [XLEN-1:0]  opa_d  [DEPTH];
  logic [XLEN-1:0]  opb_q  [DEPTH];
  logic [XLEN-1:0]  opb_d  [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             illegal_q, illegal_d;

  assign opcode = in_instruction[6:0];
  assign dst    = in_instruction[11:7];
  assign src_a  = in_instruction[19:15];
  assign src_b  = in_instruction[24:20];
  assign is_op  = (opcode == OPC_OP);
  assign legal  = is_legal_opc(opcode);

  int_scoreboard u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .set_en   (push),
    .set_rd   (dst),
    .clr_en   (wb_valid),
    .clr_rd   (wb_rd),
    .query_a  (src_a),
    .query_b  (src_b),
    .busy_a_c (busy_a),
    .busy_b_c (busy_b)
  );

`ifdef INT_ISSUE_FORWARD_EN
  // A writeback landing on a busy source releases it and supplies the operand.
  always_comb begin
    stall_a = busy_a;
    stall_b = busy_b;
    op_a    = rs1_data;
    op_b    = rs2_data;
    if (busy_a && wb_valid && (wb_rd == src_a)) begin
      stall_a = 1'b0;
      op_a    = wb_data;
    end
    if (busy_b && wb_valid && (wb_rd == src_b)) begin
      stall_b = 1'b0;
      if (is_op) op_b = wb_data;
    end
  end
`else
  logic unused_wb_data;

  always_comb begin
    stall_a = busy_a;
    stall_b = busy_b;
    op_a    = rs1_data;
    op_b    = rs2_data;
  end

  assign unused_wb_data = ^wb_data;
`endif

  // OP-IMM ignores its rs2 field, and unsupported opcodes read nothing.
  assign in_ready = (count_q < CNT_W'(DEPTH)) && !(legal && (stall_a || (is_op && stall_b)));
  assign push     = in_valid && in_ready && legal;
  assign drop     = in_valid && in_ready && !legal;
  assign pop      = out_valid && out_ready;

  always_comb begin
    meta_d    = meta_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    illegal_d = drop;
    if (push) begin
      meta_d[tail_q] = '{instr: in_instruction, rd: dst};
      opa_d[tail_q]  = op_a;
      opb_d[tail_q]  = op_b;
      tail_d         = tail_q + PTR_W'(1);
    end
    if (pop) head_d = head_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        meta_q[i] <= '0;
        opa_q[i]  <= '0;
        opb_q[i]  <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid    = (count_q != '0);
  assign instruction  = meta_q[head_q].instr;
  assign inst_type    = meta_q[head_q].instr[14:12];
  assign out_rd       = meta_q[head_q].rd;
  assign data_a       = opa_q[head_q];
  assign data_b       = opb_q[head_q];
  assign illegal_inst = illegal_q;

endmodule

// File: tb/tb_int_issue.sv
// Scoreboard bench for int_issue: directed scenarios plus random traffic against a queue/array model.
module tb_int_issue;
  import int_pkg::*;

  localparam int unsigned DEPTH = 2;
`ifdef INT_ISSUE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic [2:0]  inst_type;
  logic [63:0] data_a;
  logic [63:0] data_b;
  logic [4:0]  out_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        illegal_inst;

  int_issue #(.XLEN(64), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instruction (in_instruction),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .instruction    (instruction),
    .inst_type      (inst_type),
    .data_a         (data_a),
    .data_b         (data_b),
    .out_rd         (out_rd),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .illegal_inst   (illegal_inst)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;

  exp_t exp_q[$];
  bit   pend[32];
  int   m_cnt;
  bit   m_ill;
  int   total;
  int   bad;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] opc, input logic [4:0] rd,
                                      input logic [4:0] r1, input logic [4:0] r2,
                                      input logic [2:0] f3);
    return {7'b0, r2, r1, f3, rd, opc};
  endfunction

  // A source waits if it has an outstanding producer, unless (with forwarding) it is written back now.
  function automatic bit busy(input logic [4:0] r, input logic wbv, input logic [4:0] wrd);
    return (r != 0) && pend[r] && !(FWD && wbv && (wrd == r));
  endfunction

  function automatic bit fwd_hit(input logic [4:0] r, input logic wbv, input logic [4:0] wrd);
    return FWD && (r != 0) && pend[r] && wbv && (wrd == r);
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_cnt = 0;
    m_ill = 1'b0;
    foreach (pend[i]) pend[i] = 1'b0;
  endtask

  // Drives one cycle from posedge+1, checks at negedge, advances the model at the next posedge.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [63:0] a,
                      input logic [63:0] b, input logic ordy, input logic wbv,
                      input logic [4:0] wrd, input logic [63:0] wd, output bit acc);
    logic [6:0] opc;
    logic [4:0] r1, r2, rd;
    bit         isop, legal, rdy;
    exp_t       e;
    in_valid       = iv;
    in_instruction = ins;
    rs1_data       = a;
    rs2_data       = b;
    out_ready      = ordy;
    wb_valid       = wbv;
    wb_rd          = wrd;
    wb_data        = wd;
    opc   = ins[6:0];
    r1    = ins[19:15];
    r2    = ins[24:20];
    rd    = ins[11:7];
    isop  = (opc == OPC_OP);
    legal = isop || (opc == OPC_OP_IMM);
    rdy   = (m_cnt < DEPTH) && !(legal && (busy(r1, wbv, wrd) || (isop && busy(r2, wbv, wrd))));
    @(negedge clock);
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("out_valid", 64'(out_valid), 64'(m_cnt > 0));
    chk("illegal_inst", 64'(illegal_inst), 64'(m_ill));
    @(posedge clock);
    acc   = iv && rdy;
    m_ill = acc && !legal;
    if ((m_cnt > 0) && ordy) m_cnt--;
    if (acc && legal) begin
      e.instr = ins;
      e.rd    = rd;
      e.a     = fwd_hit(r1, wbv, wrd) ? wd : a;
      e.b     = (isop && fwd_hit(r2, wbv, wrd)) ? wd : b;
      exp_q.push_back(e);
      m_cnt++;
    end
    if (wbv && (wrd != 0)) pend[wrd] = 1'b0;
    if (acc && legal && (rd != 0)) pend[rd] = 1'b1;
    #1;
  endtask

  task automatic idle(input logic ordy, input logic wbv, input logic [4:0] wrd);
    bit acc;
    step(1'b0, 32'h0, 64'h0, 64'h0, ordy, wbv, wrd, 64'h0, acc);
  endtask

  // Head entry must match the oldest expected entry every cycle it is presented.
  always @(negedge clock) begin
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL head: out_valid=1 but expected queue empty at %0t", $time);
      end else begin
        chk("instruction", 64'(instruction), 64'(exp_q[0].instr));
        chk("inst_type", 64'(inst_type), 64'(exp_q[0].instr[14:12]));
        chk("data_a", data_a, exp_q[0].a);
        chk("data_b", data_b, exp_q[0].b);
        chk("out_rd", 64'(out_rd), 64'(exp_q[0].rd));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bit          acc;
    logic [31:0] sub_i;
    logic [31:0] ins;
    logic [6:0]  opc;
    int          sel;

    reset = 1'b0;
    in_valid = 1'b0; in_instruction = '0; rs1_data = '0; rs2_data = '0;
    out_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    model_clear();
    #3;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset illegal", 64'(illegal_inst), 64'd0);
    chk("reset instruction", 64'(instruction), 64'd0);
    chk("reset data_a", data_a, 64'd0);
    chk("reset data_b", data_b, 64'd0);
    chk("reset out_rd", 64'(out_rd), 64'd0);
    #9 reset = 1'b1;
    @(posedge clock); #1;

    // ADD x3,x1,x2 then dependent SUB x4,x3,x1 with a writeback of x3.
    step(1'b1, enc(OPC_OP, 5'd3, 5'd1, 5'd2, 3'b000), 64'd5, 64'd7, 1'b1, 1'b0, 5'd0, 64'd0, acc);
    sub_i = enc(OPC_OP, 5'd4, 5'd3, 5'd1, 3'b000) | 32'h4000_0000;
    step(1'b1, sub_i, 64'd0, 64'd5, 1'b1, 1'b0, 5'd0, 64'd0, acc);
    step(1'b1, sub_i, 64'd0, 64'd5, 1'b1, 1'b1, 5'd3, 64'd12, acc);
    if (!acc) step(1'b1, sub_i, 64'd12, 64'd5, 1'b1, 1'b0, 5'd0, 64'd0, acc);
    idle(1'b1, 1'b1, 5'd4);
    idle(1'b1, 1'b0, 5'd0);

    // Fill with out_ready low, attempt a third, then drain.
    step(1'b1, enc(OPC_OP_IMM, 5'd7, 5'd0, 5'd0, 3'b000), 64'h11, 64'h22, 1'b0, 1'b0, 5'd0, 64'd0, acc);
    step(1'b1, enc(OPC_OP, 5'd8, 5'd1, 5'd2, 3'b111), 64'h33, 64'h44, 1'b0, 1'b0, 5'd0, 64'd0, acc);
    step(1'b1, enc(OPC_OP, 5'd9, 5'd1, 5'd2, 3'b110), 64'h55, 64'h66, 1'b0, 1'b0, 5'd0, 64'd0, acc);
    idle(1'b0, 1'b0, 5'd0);
    idle(1'b1, 1'b1, 5'd7);
    idle(1'b1, 1'b1, 5'd8);
    idle(1'b1, 1'b0, 5'd0);

    // x0 is never busy; OP-IMM ignores a pending register in its rs2 field.
    step(1'b1, enc(OPC_OP_IMM, 5'd5, 5'd0, 5'd1, 3'b000), 64'd0, 64'd9, 1'b1, 1'b0, 5'd0, 64'd0, acc);
    step(1'b1, enc(OPC_OP, 5'd6, 5'd0, 5'd0, 3'b000), 64'd0, 64'd0, 1'b1, 1'b0, 5'd0, 64'd0, acc);
    step(1'b1, enc(OPC_OP_IMM, 5'd10, 5'd0, 5'd5, 3'b100), 64'd1, 64'd2, 1'b1, 1'b0, 5'd0, 64'd0, acc);
    idle(1'b1, 1'b1, 5'd5);

    // Unsupported opcode: dropped with a one-cycle illegal pulse.
    step(1'b1, enc(OPC_LOAD, 5'd11, 5'd6, 5'd6, 3'b011), 64'd1, 64'd2, 1'b1, 1'b0, 5'd0, 64'd0, acc);
    idle(1'b1, 1'b0, 5'd0);
    idle(1'b1, 1'b1, 5'd6);
    idle(1'b1, 1'b1, 5'd10);

    // Asynchronous reset with a full buffer and x3 pending.
    step(1'b1, enc(OPC_OP, 5'd3, 5'd1, 5'd2, 3'b000), 64'hA, 64'hB, 1'b0, 1'b0, 5'd0, 64'd0, acc);
    step(1'b1, enc(OPC_OP_IMM, 5'd12, 5'd1, 5'd0, 3'b001), 64'hC, 64'hD, 1'b0, 1'b0, 5'd0, 64'd0, acc);
    in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("async out_valid", 64'(out_valid), 64'd0);
    chk("async instruction", 64'(instruction), 64'd0);
    chk("async data_a", data_a, 64'd0);
    chk("async out_rd", 64'(out_rd), 64'd0);
    model_clear();
    #1 reset = 1'b1;
    @(posedge clock); #1;
    step(1'b1, enc(OPC_OP, 5'd13, 5'd3, 5'd12, 3'b000), 64'h1, 64'h2, 1'b1, 1'b0, 5'd0, 64'd0, acc);
    idle(1'b1, 1'b1, 5'd13);

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 5)      opc = OPC_OP;
      else if (sel < 9) opc = OPC_OP_IMM;
      else              opc = ($urandom_range(0, 1) == 0) ? OPC_LOAD : 7'($urandom);
      ins = enc(opc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 3'($urandom));
      ins[31:25] = 7'($urandom);
      step(1'b1 && ($urandom_range(0, 3) != 0), ins, {$urandom, $urandom}, {$urandom, $urandom},
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)),
           {$urandom, $urandom}, acc);
    end

    for (int n = 0; n < 8; n++) idle(1'b1, 1'b1, 5'(n));
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
